// File: rtl/mbus_reset_sequencer.sv
// mbus_reset_sequencer
// Generates the mbus domain reset and clock-gate enable. Reset assertion is
// asynchronous and reset release is synchronized. A software-requested domain
// reset first drains the bus, with a timeout, and then replays the hold sequence.
// Every output is driven straight from a flop.
module mbus_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int CLKEN_LEAD    = 4,
    parameter int DRAIN_TIMEOUT = 256,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_rst_req,
    input  logic             drain_ack,
    output logic             drain_req,
    output logic             out_reset,
    output logic             out_clock_en,
    output logic             ready,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] rst_count
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] CLKEN_AT  = HOLD_W'(HOLD_CYCLES - CLKEN_LEAD);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_HOLD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // The last synchronizer stage is the SYNC->HOLD transition itself, so only
    // SYNC_STAGES-1 dedicated flops are needed ahead of the state register.
    logic [SYNC_STAGES-2:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_next;

    state_t            r_state;
    state_t            w_state_next;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_next;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_next;
    logic              r_timeout;
    logic              w_timeout_next;
    logic [CNT_W-1:0]  r_rst_count;
    logic [CNT_W-1:0]  w_count_next;

    logic r_out_reset;
    logic r_clock_en;
    logic r_drain_req;
    logic r_ready;
    logic w_out_reset_next;
    logic w_clock_en_next;
    logic w_drain_req_next;
    logic w_ready_next;

    assign w_sync_next = {r_sync, 1'b1};

    // Next-state, counter and registered-output decode.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case leaves a value unassigned and no latch is inferred.
        w_state_next   = r_state;
        w_hold_next    = r_hold_cnt;
        w_to_next      = r_to_cnt;
        w_timeout_next = r_timeout;
        w_count_next   = r_rst_count;

        unique case (r_state)
            S_SYNC: begin
                if (w_sync_next[SYNC_STAGES-1]) begin
                    w_state_next = S_HOLD;
                    w_hold_next  = '0;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = S_RUN;
                    if (r_rst_count != '1) begin
                        w_count_next = r_rst_count + CNT_W'(1);
                    end
                end else begin
                    w_hold_next = r_hold_cnt + HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (soft_rst_req) begin
                    w_state_next = S_DRAIN;
                    w_to_next    = '0;
                end
            end
            S_DRAIN: begin
                // An ack in the final timeout cycle still counts as an ack.
                if (drain_ack) begin
                    w_state_next = S_HOLD;
                    w_hold_next  = '0;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next   = S_HOLD;
                    w_hold_next    = '0;
                    w_timeout_next = 1'b1;
                end else begin
                    w_to_next = r_to_cnt + TO_W'(1);
                end
            end
            default: w_state_next = S_SYNC;
        endcase

        // Outputs are decoded from the next state and flopped with it.
        w_ready_next     = (w_state_next == S_RUN);
        w_drain_req_next = (w_state_next == S_DRAIN);
        w_out_reset_next = !(w_state_next == S_RUN || w_state_next == S_DRAIN);
        w_clock_en_next  = (w_state_next == S_RUN) || (w_state_next == S_DRAIN) ||
                           ((w_state_next == S_HOLD) && (w_hold_next >= CLKEN_AT));
    end

    // State, counters and outputs; all return to reset values asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync      <= '0;
            r_state     <= S_SYNC;
            r_hold_cnt  <= '0;
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
            r_rst_count <= '0;
            r_out_reset <= 1'b1;
            r_clock_en  <= 1'b0;
            r_drain_req <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            r_sync      <= w_sync_next[SYNC_STAGES-2:0];
            r_state     <= w_state_next;
            r_hold_cnt  <= w_hold_next;
            r_to_cnt    <= w_to_next;
            r_timeout   <= w_timeout_next;
            r_rst_count <= w_count_next;
            r_out_reset <= w_out_reset_next;
            r_clock_en  <= w_clock_en_next;
            r_drain_req <= w_drain_req_next;
            r_ready     <= w_ready_next;
        end
    end

    assign out_reset    = r_out_reset;
    assign out_clock_en = r_clock_en;
    assign drain_req    = r_drain_req;
    assign ready        = r_ready;
    assign timeout_flag = r_timeout;
    assign rst_count    = r_rst_count;

endmodule

// File: tb/tb_mbus_reset_sequencer.sv
// Directed testbench for mbus_reset_sequencer. One instance uses the default
// parameters. A second, small instance (CNT_W=2) covers counter saturation.
module tb_mbus_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       drain_ack = 1'b0;
    logic       drain_req, out_reset, out_clock_en, ready, timeout_flag;
    logic [7:0] rst_count;

    logic       s_soft = 1'b0;
    logic       s_ack = 1'b0;
    logic       s_drain_req, s_out_reset, s_clock_en, s_ready, s_timeout;
    logic [1:0] s_rst_count;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    mbus_reset_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .soft_rst_req (soft_rst_req),
        .drain_ack    (drain_ack),
        .drain_req    (drain_req),
        .out_reset    (out_reset),
        .out_clock_en (out_clock_en),
        .ready        (ready),
        .timeout_flag (timeout_flag),
        .rst_count    (rst_count)
    );

    mbus_reset_sequencer #(
        .SYNC_STAGES   (2),
        .HOLD_CYCLES   (4),
        .CLKEN_LEAD    (2),
        .DRAIN_TIMEOUT (8),
        .CNT_W         (2)
    ) dut_sat (
        .clock        (clock),
        .reset        (reset),
        .soft_rst_req (s_soft),
        .drain_ack    (s_ack),
        .drain_req    (s_drain_req),
        .out_reset    (s_out_reset),
        .out_clock_en (s_clock_en),
        .ready        (s_ready),
        .timeout_flag (s_timeout),
        .rst_count    (s_rst_count)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        if (reset) edge_n++;
        #1;
    endtask

    task automatic tick_to(input int n);
        while (edge_n < n) tick();
    endtask

    // Release reset just after a rising edge, so the next edge is edge 1.
    task automatic release_reset();
        @(posedge clock);
        #1;
        edge_n = 0;
        reset  = 1'b1;
    endtask

    task automatic wait_ready(input bit use_sat, input string name);
        int i;
        for (i = 0; i < 64; i++) begin
            if (use_sat ? s_ready : ready) break;
            tick();
        end
        checks++;
        if (i == 64) begin
            errors++;
            $display("FAIL %s wait_ready: ready still low after 64 cycles, required high", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({out_reset, out_clock_en, drain_req, ready, timeout_flag} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 10000",
                     {out_reset, out_clock_en, drain_req, ready, timeout_flag});
        end
        checks++;
        if (rst_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", rst_count);
        end
    endtask

    // Cold start: clock enable at edge 14, reset release and ready at edge 18.
    // With noise set, soft_rst_req and drain_ack are held high through HOLD.
    task automatic test_cold_start(input bit noise, input logic [7:0] exp_count);
        logic exp_en, exp_rst, exp_rdy;
        release_reset();
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_en  = (n >= 14);
            exp_rst = (n < 18);
            exp_rdy = (n >= 18);
            checks++;
            if (out_clock_en !== exp_en) begin
                errors++;
                $display("FAIL cold out_clock_en edge %0d: got %b required %b", n, out_clock_en, exp_en);
            end
            checks++;
            if (out_reset !== exp_rst) begin
                errors++;
                $display("FAIL cold out_reset edge %0d: got %b required %b", n, out_reset, exp_rst);
            end
            checks++;
            if (ready !== exp_rdy) begin
                errors++;
                $display("FAIL cold ready edge %0d: got %b required %b", n, ready, exp_rdy);
            end
            checks++;
            if (drain_req !== 1'b0) begin
                errors++;
                $display("FAIL cold drain_req edge %0d: got %b required 0", n, drain_req);
            end
            if (n == 18) begin
                checks++;
                if (rst_count !== exp_count) begin
                    errors++;
                    $display("FAIL cold rst_count: got %0d required %0d", rst_count, exp_count);
                end
            end
            if (noise && n == 2) begin
                soft_rst_req = 1'b1;
                drain_ack    = 1'b1;
            end
            if (noise && n == 17) begin
                soft_rst_req = 1'b0;
                drain_ack    = 1'b0;
            end
        end
    endtask

    // Request sampled at edge 30, ack sampled at edge 35.
    task automatic test_soft_reset();
        logic exp_dr, exp_rst, exp_en;
        tick_to(29);
        soft_rst_req = 1'b1;
        for (int e = 30; e <= 52; e++) begin
            tick();
            if (e == 30) soft_rst_req = 1'b0;
            if (e == 34) drain_ack = 1'b1;
            if (e == 35) drain_ack = 1'b0;
            exp_dr  = (e < 35);
            exp_rst = (e >= 35 && e < 51);
            exp_en  = !(e >= 35 && e < 47);
            checks++;
            if (drain_req !== exp_dr) begin
                errors++;
                $display("FAIL soft drain_req edge %0d: got %b required %b", e, drain_req, exp_dr);
            end
            checks++;
            if (out_reset !== exp_rst) begin
                errors++;
                $display("FAIL soft out_reset edge %0d: got %b required %b", e, out_reset, exp_rst);
            end
            checks++;
            if (out_clock_en !== exp_en) begin
                errors++;
                $display("FAIL soft out_clock_en edge %0d: got %b required %b", e, out_clock_en, exp_en);
            end
            checks++;
            if (ready !== (e >= 51)) begin
                errors++;
                $display("FAIL soft ready edge %0d: got %b required %b", e, ready, (e >= 51));
            end
        end
        checks++;
        if (rst_count !== 8'd2 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL soft end_state: rst_count=%0d timeout=%b required 2 and 0", rst_count, timeout_flag);
        end
    endtask

    task automatic test_timeout();
        int highs = 0;
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!drain_req) break;
            highs++;
            tick();
        end
        checks++;
        if (highs != 256) begin
            errors++;
            $display("FAIL timeout drain_req_len: got %0d cycles required 256", highs);
        end
        checks++;
        if (out_reset !== 1'b1 || timeout_flag !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout exit: out_reset=%b timeout=%b ready=%b required 1 1 0",
                     out_reset, timeout_flag, ready);
        end
        wait_ready(1'b0, "timeout");
        checks++;
        if (timeout_flag !== 1'b1 || rst_count !== 8'd3) begin
            errors++;
            $display("FAIL timeout sticky: timeout=%b rst_count=%0d required 1 and 3", timeout_flag, rst_count);
        end
    endtask

    // Reset asserted between edges must act with no further clock edge.
    task automatic test_reset_mid_operation();
        #2;
        reset  = 1'b0;
        edge_n = 0;
        #1;
        checks++;
        if ({out_reset, out_clock_en, ready, timeout_flag} !== 4'b1000 || rst_count !== 8'd0) begin
            errors++;
            $display("FAIL async_from_run: out_reset/en/ready/timeout=%b rst_count=%0d required 1000 and 0",
                     {out_reset, out_clock_en, ready, timeout_flag}, rst_count);
        end
        release_reset();
        tick_to(10);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_reset, out_clock_en, drain_req, ready} !== 4'b1000) begin
            errors++;
            $display("FAIL async_mid_hold: got %b required 1000", {out_reset, out_clock_en, drain_req, ready});
        end
        test_cold_start(1'b1, 8'd1);
    endtask

    // Ack sampled exactly on the edge that would otherwise time out.
    task automatic test_ack_final();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        repeat (255) tick();
        checks++;
        if (drain_req !== 1'b1 || out_reset !== 1'b0) begin
            errors++;
            $display("FAIL ack_final pre: drain_req=%b out_reset=%b required 1 0", drain_req, out_reset);
        end
        drain_ack = 1'b1;
        tick();
        drain_ack = 1'b0;
        checks++;
        if (out_reset !== 1'b1 || drain_req !== 1'b0 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL ack_final exit: out_reset=%b drain_req=%b timeout=%b required 1 0 0",
                     out_reset, drain_req, timeout_flag);
        end
        wait_ready(1'b0, "ack_final");
        checks++;
        if (rst_count !== 8'd2 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL ack_final end: rst_count=%0d timeout=%b required 2 0", rst_count, timeout_flag);
        end
    endtask

    // CNT_W=2: five soft resets after the cold start leave rst_count at 3.
    task automatic test_saturation();
        logic [1:0] exp_cnt;
        wait_ready(1'b1, "sat_initial");
        checks++;
        if (s_rst_count !== 2'd1) begin
            errors++;
            $display("FAIL sat initial rst_count: got %0d required 1", s_rst_count);
        end
        for (int i = 1; i <= 5; i++) begin
            s_soft = 1'b1;
            tick();
            s_soft = 1'b0;
            checks++;
            if (s_drain_req !== 1'b1) begin
                errors++;
                $display("FAIL sat drain_req round %0d: got %b required 1", i, s_drain_req);
            end
            s_ack = 1'b1;
            tick();
            s_ack = 1'b0;
            checks++;
            if (s_out_reset !== 1'b1) begin
                errors++;
                $display("FAIL sat out_reset round %0d: got %b required 1", i, s_out_reset);
            end
            wait_ready(1'b1, "sat_round");
            exp_cnt = (i >= 2) ? 2'd3 : 2'd2;
            checks++;
            if (s_rst_count !== exp_cnt || s_timeout !== 1'b0) begin
                errors++;
                $display("FAIL sat rst_count round %0d: got %0d timeout=%b required %0d 0",
                         i, s_rst_count, s_timeout, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_start(1'b0, 8'd1);
        test_soft_reset();
        test_timeout();
        test_reset_mid_operation();
        test_ack_final();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
